pq_stim_ctrl: RTL
=================

PQ_STIM_CTRL -- requirements
Module: pq_stim_ctrl

Interface
REQ-001 SHALL have no parameters; all widths fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset.
REQ-004 start  input  1  request a burst; sampled only in IDLE.
REQ-005 count  input  8  number of keys in the burst, sampled with start; 0 is legal.
REQ-006 lfsr_q  input  8  current value from lfsr8_e q.
REQ-007 lfsr_enb  output  1  drives lfsr8_e enb; advances the LFSR one step per cycle high.
REQ-008 key  output  8  random key toward the priority-queue DUV.
REQ-009 key_valid  output  1  key is offered.
REQ-010 key_ready  input  1  consumer accepts the key; a handshake is key_valid & key_ready in the same cycle.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 done  output  1  one-cycle pulse at end of burst.

Function
REQ-013 SHALL implement FSM states IDLE, SEND and FIN.
REQ-014 IDLE: start=1 with count!=0 -> SEND, remaining <= count; start=1 with count==0 -> FIN; otherwise stay.
REQ-015 SEND: key_valid=1; key = lfsr_q (combinational pass-through); lfsr_enb = key_ready.
REQ-016 Key held stable while key_valid & !key_ready: LFSR not enabled, so key cannot change.
REQ-017 Each handshake decrements remaining (8-bit); handshake with remaining==1 -> FIN.
REQ-018 FIN: done=1 for exactly one cycle, key_valid=0, lfsr_enb=0 -> IDLE.
REQ-019 First key_valid appears the cycle after the edge that samples start; back-to-back keys at one per cycle while key_ready=1.
REQ-020 lfsr_enb SHALL be high only in SEND handshake cycles; number of enb cycles equals keys delivered.
REQ-021 start asserted outside IDLE, including in FIN, SHALL be ignored; count is not resampled.
REQ-022 Outside SEND: key_valid=0, lfsr_enb=0, key=0.

Reset
REQ-023 rst=0 at a rising edge: state=IDLE, remaining=0; all outputs 0 in the following cycle, regardless of current state, including mid-burst.
REQ-024 Controller reset does not reset the LFSR; the bench resets lfsr8_e separately.

Configuration
REQ-025 Macro PQ_STIM_ABORT_EN, when defined, adds port abort (input, 1).
REQ-026 With PQ_STIM_ABORT_EN: abort=1 in SEND -> FIN next cycle. A handshake in the same cycle still counts and still advances the LFSR. abort is ignored in other states.
REQ-027 Without PQ_STIM_ABORT_EN: no abort port; bursts end only on count exhaustion or reset.

Verification
REQ-028 count=3, key_ready=1 constant -> key_valid high 3 consecutive cycles; key equals the lfsr_q value in each of those cycles, giving 3 successive LFSR states; lfsr_enb high 3 cycles; done high in the 4th cycle; busy low in the 5th.
REQ-029 count=0, start=1 -> next cycle done=1, key_valid=0, lfsr_enb=0; then IDLE.
REQ-030 count=2, key_ready low for the first 5 SEND cycles -> key constant, lfsr_enb=0 for those 5 cycles; then 2 handshakes, then done.
REQ-031 start pulsed with count=9 mid-burst of count=4 -> exactly 4 handshakes, one done pulse.
REQ-032 rst=0 during the 2nd key of count=5 -> next cycle busy=0, key_valid=0, done=0; a new start with count=1 yields exactly 1 key.
REQ-033 (PQ_STIM_ABORT_EN) count=10, abort on the 3rd handshake cycle -> 3 keys delivered, done next cycle.

Source files
------------

// File: rtl/pq_stim_ctrl.sv
// ---------------------------------------------------------------------------
// pq_stim_ctrl
//
// Purpose:
//   Stimulus controller that feeds a burst of pseudo-random keys to a
//   priority-queue design under test. On a start request in IDLE it latches
//   the burst length. It then offers one key per cycle through a
//   valid/ready handshake, and ends with a one-cycle done pulse.
//   The key is the current value of an external 8-bit LFSR. That LFSR is
//   stepped only on handshake cycles, so a stalled key stays stable.
//
// Ports:
//   clk        in   1  clock, all state changes on the rising edge
//   rst        in   1  synchronous reset, active low
//   start      in   1  burst request, honoured only in IDLE
//   count      in   8  burst length sampled with start (0 = empty burst)
//   lfsr_q     in   8  current LFSR state
//   lfsr_enb   out  1  LFSR step enable (high only on handshake cycles)
//   key        out  8  key offered to the consumer (0 outside SEND)
//   key_valid  out  1  key is being offered
//   key_ready  in   1  consumer accepts the key this cycle
//   abort      in   1  (only with PQ_STIM_ABORT_EN) end the burst early
//   busy       out  1  controller is not in IDLE
//   done       out  1  one-cycle pulse when a burst completes
//
// Build option:
//   PQ_STIM_ABORT_EN  adds the abort input. When abort is high in SEND, the
//                     controller moves to FIN on the next edge. A handshake
//                     in that same cycle still counts.
// ---------------------------------------------------------------------------
module pq_stim_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] count,
    input  logic [7:0] lfsr_q,
    output logic       lfsr_enb,
    output logic [7:0] key,
    output logic       key_valid,
    input  logic       key_ready,
`ifdef PQ_STIM_ABORT_EN
    input  logic       abort,
`endif
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] remaining_q;
    logic [7:0] remaining_d;
    logic       valid_q;
    logic       done_q;
    logic       busy_q;
    logic       handshake;
    logic       abort_req;

`ifdef PQ_STIM_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // valid_q is high only in SEND, so this is a SEND-cycle handshake.
    assign handshake   = valid_q & key_ready;
    assign remaining_d = remaining_q - 8'd1;

    // Step the LFSR only when the key is consumed. A stalled key therefore
    // cannot change under the consumer.
    assign lfsr_enb  = handshake;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // The key passes straight through from the LFSR while offered.
    // It is forced to zero in every other state.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_key_gate
            assign key[gi] = lfsr_q[gi] & valid_q;
        end
    endgenerate

    // State and the registered outputs are updated together. Each output
    // register always matches the state the FSM is entering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= 8'd0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (count != 8'd0) begin
                            state_q     <= SEND;
                            remaining_q <= count;
                            valid_q     <= 1'b1;
                        end else begin
                            // An empty burst still reports completion.
                            state_q <= FIN;
                            done_q  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (handshake) begin
                        remaining_q <= remaining_d;
                    end
                    if ((handshake && (remaining_q == 8'd1)) || abort_req) begin
                        state_q <= FIN;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FIN: begin
                    // Any start seen here is dropped on purpose.
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
